flash_audio_streamer: RTL

- Parametrised flash-to-codec playback engine. An Avalon-MM read master fetches packed sample words from flash and feeds them to the audio codec write FIFO through the write_ready/write_s handshake.
- Adds behaviour the current player lacks: mono or stereo packing, forward or reverse playback, loop or one-shot, pause, and a programmable attenuation shift.
- Sits between the flash IP and audio_codec in the board top level.

---
 rtl/flash_audio_pkg.sv | 36 +++
 rtl/flash_word_fetcher.sv | 99 +++++++++
 rtl/flash_audio_streamer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_audio_pkg.sv
// Shared types, slot constants and the sample attenuation helper for the
// flash-to-codec playback engine.
package flash_audio_pkg;

    // Playback sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_DATA  = 3'd2,
        ST_SLOT_WAIT  = 3'd3,
        ST_SLOT_WRITE = 3'd4,
        ST_SLOT_DRAIN = 3'd5,
        ST_NEXT       = 3'd6
    } state_e;

    // Avalon read handshake states inside the word fetcher.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    // Codec slots consumed per flash word.
    localparam int unsigned SLOT_MONO   = 32'd2;
    localparam int unsigned SLOT_STEREO = 32'd1;

    // Signed arithmetic right shift (sign-fill). Callers sign-extend their
    // sample to 32 bits and truncate the result back to the sample width.
    function automatic logic signed [31:0] attenuate(
        input logic signed [31:0] sample,
        input logic        [7:0]  shift
    );
        return sample >>> shift;
    endfunction

endpackage

// File: rtl/flash_word_fetcher.sv
// Avalon-MM single-word read master. One issue pulse launches a read at the
// supplied address; the read is held through waitrequest, and the returned
// word is captured either in the acceptance cycle or in a later
// readdatavalid cycle. word_valid flags the cycle in which the word lands.
module flash_word_fetcher
    import flash_audio_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32'd23,
    parameter int unsigned DATA_W    = 32'd32,
    parameter int unsigned BASE_ADDR = 32'd0
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic              accept,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    fetch_state_e      fstate_r;
    logic              read_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] word_r;
    logic              accept_s;
    logic              valid_s;

    assign mem_read    = read_r;
    assign mem_address = addr_r;
    assign accept      = accept_s;
    assign word_valid  = valid_s;
    assign word        = word_r;

    // Decode read acceptance and data arrival for the current cycle.
    always_comb begin
        accept_s = 1'b0;
        valid_s  = 1'b0;
        case (fstate_r)
            FETCH_REQ: begin
                accept_s = ~waitrequest;
                valid_s  = ~waitrequest & readdatavalid;
            end
            FETCH_WAIT: begin
                valid_s = readdatavalid;
            end
            default: begin
                accept_s = 1'b0;
                valid_s  = 1'b0;
            end
        endcase
    end

    // Read request / data capture sequencer.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fstate_r <= FETCH_IDLE;
            read_r   <= 1'b0;
            addr_r   <= ADDR_W'(BASE_ADDR);
            word_r   <= '0;
        end else begin
            case (fstate_r)
                FETCH_IDLE: begin
                    if (issue) begin
                        read_r   <= 1'b1;
                        addr_r   <= issue_addr;
                        fstate_r <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (accept_s) begin
                        read_r <= 1'b0;
                        if (valid_s) begin
                            word_r   <= readdata;
                            fstate_r <= FETCH_IDLE;
                        end else begin
                            fstate_r <= FETCH_WAIT;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (valid_s) begin
                        word_r   <= readdata;
                        fstate_r <= FETCH_IDLE;
                    end
                end
                default: begin
                    read_r   <= 1'b0;
                    fstate_r <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/flash_audio_streamer.sv
// Flash-to-codec playback engine: walks a clip of packed sample words
// forward or backward, unpacks mono or stereo slots, attenuates them and
// hands them to the codec FIFO one strobe at a time. Supports looping,
// one-shot with a done pulse, and pause at word boundaries.
module flash_audio_streamer
    import flash_audio_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32'd23,
    parameter int unsigned SAMPLE_W  = 32'd16,
    parameter int unsigned BASE_ADDR = 32'd0,
    parameter int unsigned NUM_WORDS = 32'h0020_0000,
    parameter int unsigned SHIFT_W   = 32'd3
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  loop_en,
    input  logic                  reverse,
    input  logic                  stereo,
    input  logic [SHIFT_W-1:0]    atten,
    output logic                  flash_mem_read,
    output logic [ADDR_W-1:0]     flash_mem_address,
    output logic [3:0]            flash_mem_byteenable,
    input  logic                  flash_mem_waitrequest,
    input  logic [2*SAMPLE_W-1:0] flash_mem_readdata,
    input  logic                  flash_mem_readdatavalid,
    input  logic                  write_ready,
    output logic                  write_s,
    output logic [SAMPLE_W-1:0]   writedata_left,
    output logic [SAMPLE_W-1:0]   writedata_right,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W-1:0] START_FWD   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] START_REV   = ADDR_W'(BASE_ADDR + NUM_WORDS - 32'd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(32'd1);
    localparam logic [ADDR_W:0]   NUM_WORDS_C = (ADDR_W + 32'd1)'(NUM_WORDS);
    localparam logic [ADDR_W:0]   CNT_ONE     = (ADDR_W + 32'd1)'(32'd1);

    state_e                 state_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [ADDR_W:0]        cnt_r;
    logic                   reverse_r;
    logic                   stereo_r;
    logic [1:0]             slot_r;
    logic [SHIFT_W-1:0]     atten_r;
    logic                   write_r;
    logic [SAMPLE_W-1:0]    left_r;
    logic [SAMPLE_W-1:0]    right_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   issue_s;
    logic [ADDR_W-1:0]      issue_addr_s;
    logic                   fetch_accept_s;
    logic                   fetch_valid_s;
    logic [2*SAMPLE_W-1:0]  fetch_word_s;
    logic [ADDR_W:0]        cnt_inc_s;
    logic [ADDR_W-1:0]      addr_step_s;
    logic [ADDR_W-1:0]      start_addr_s;
    logic [SAMPLE_W-1:0]    lo_s;
    logic [SAMPLE_W-1:0]    hi_s;
    logic [1:0]             slots_s;
    logic                   last_slot_s;
    logic [SAMPLE_W-1:0]    left_raw_s;
    logic [SAMPLE_W-1:0]    right_raw_s;
    logic signed [SAMPLE_W-1:0] left_sg_s;
    logic signed [SAMPLE_W-1:0] right_sg_s;
    logic [SAMPLE_W-1:0]    left_att_s;
    logic [SAMPLE_W-1:0]    right_att_s;

    assign flash_mem_byteenable = 4'b1111;
    assign write_s              = write_r;
    assign writedata_left       = left_r;
    assign writedata_right      = right_r;
    assign busy                 = busy_r;
    assign done                 = done_r;

    flash_word_fetcher #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (2 * SAMPLE_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_fetcher (
        .clk           (clk),
        .resetb        (resetb),
        .issue         (issue_s),
        .issue_addr    (issue_addr_s),
        .waitrequest   (flash_mem_waitrequest),
        .readdata      (flash_mem_readdata),
        .readdatavalid (flash_mem_readdatavalid),
        .mem_read      (flash_mem_read),
        .mem_address   (flash_mem_address),
        .accept        (fetch_accept_s),
        .word_valid    (fetch_valid_s),
        .word          (fetch_word_s)
    );

    // Decide when to launch a flash read and at which word address.
    always_comb begin
        cnt_inc_s    = cnt_r + CNT_ONE;
        addr_step_s  = reverse_r ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        start_addr_s = reverse_r ? START_REV : START_FWD;
        issue_s      = 1'b0;
        issue_addr_s = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    issue_s      = 1'b1;
                    issue_addr_s = reverse ? START_REV : START_FWD;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_NEXT: begin
                if (pause) begin
                    issue_s = 1'b0;
                end else if (cnt_inc_s < NUM_WORDS_C) begin
                    issue_s      = 1'b1;
                    issue_addr_s = addr_step_s;
                end else if (loop_en) begin
                    issue_s      = 1'b1;
                    issue_addr_s = start_addr_s;
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Pick the sample(s) for the current slot and attenuate them.
    always_comb begin
        lo_s        = fetch_word_s[SAMPLE_W-1:0];
        hi_s        = fetch_word_s[2*SAMPLE_W-1:SAMPLE_W];
        slots_s     = stereo_r ? 2'(SLOT_STEREO) : 2'(SLOT_MONO);
        last_slot_s = ((slot_r + 2'd1) == slots_s);
        if (stereo_r) begin
            left_raw_s  = lo_s;
            right_raw_s = hi_s;
        end else if ((slot_r[0] ^ reverse_r) == 1'b1) begin
            left_raw_s  = hi_s;
            right_raw_s = hi_s;
        end else begin
            left_raw_s  = lo_s;
            right_raw_s = lo_s;
        end
        left_sg_s   = left_raw_s;
        right_sg_s  = right_raw_s;
        left_att_s  = SAMPLE_W'(attenuate(32'(left_sg_s), 8'(atten_r)));
        right_att_s = SAMPLE_W'(attenuate(32'(right_sg_s), 8'(atten_r)));
    end

    // Playback sequencer with registered codec and status outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r   <= ST_IDLE;
            addr_r    <= START_FWD;
            cnt_r     <= '0;
            reverse_r <= 1'b0;
            stereo_r  <= 1'b0;
            slot_r    <= 2'd0;
            atten_r   <= '0;
            write_r   <= 1'b0;
            left_r    <= '0;
            right_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        reverse_r <= reverse;
                        stereo_r  <= stereo;
                        addr_r    <= issue_addr_s;
                        cnt_r     <= '0;
                        slot_r    <= 2'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fetch_accept_s) begin
                        if (fetch_valid_s) begin
                            atten_r <= atten;
                            slot_r  <= 2'd0;
                            state_r <= ST_SLOT_WAIT;
                        end else begin
                            state_r <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (fetch_valid_s) begin
                        atten_r <= atten;
                        slot_r  <= 2'd0;
                        state_r <= ST_SLOT_WAIT;
                    end
                end
                ST_SLOT_WAIT: begin
                    if (write_ready) begin
                        left_r  <= left_att_s;
                        right_r <= right_att_s;
                        write_r <= 1'b1;
                        state_r <= ST_SLOT_WRITE;
                    end
                end
                ST_SLOT_WRITE: begin
                    write_r <= 1'b0;
                    state_r <= ST_SLOT_DRAIN;
                end
                ST_SLOT_DRAIN: begin
                    if (!write_ready) begin
                        if (last_slot_s) begin
                            state_r <= ST_NEXT;
                        end else begin
                            slot_r  <= slot_r + 2'd1;
                            state_r <= ST_SLOT_WAIT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (!pause) begin
                        if (cnt_inc_s < NUM_WORDS_C) begin
                            cnt_r   <= cnt_inc_s;
                            addr_r  <= issue_addr_s;
                            state_r <= ST_REQ;
                        end else if (loop_en) begin
                            cnt_r   <= '0;
                            addr_r  <= issue_addr_s;
                            state_r <= ST_REQ;
                        end else begin
                            cnt_r   <= cnt_inc_s;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    write_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
